// File: rtl/filter_sequencer_if.sv
// Sample/flush handshake and windowed-average results for filter_sequencer.
interface filter_sequencer_if;
    logic               sample_valid;
    logic signed [9:0]  accel_x;
    logic signed [9:0]  accel_y;
    logic signed [9:0]  accel_z;
    logic               flush;
    logic               ready;
    logic signed [9:0]  accel_x_out;
    logic signed [9:0]  accel_y_out;
    logic signed [9:0]  accel_z_out;
    logic               data_ready;
    logic               primed;
    logic               overrun;

    modport master (
        output sample_valid, accel_x, accel_y, accel_z, flush,
        input  ready, accel_x_out, accel_y_out, accel_z_out, data_ready, primed, overrun
    );

    modport slave (
        input  sample_valid, accel_x, accel_y, accel_z, flush,
        output ready, accel_x_out, accel_y_out, accel_z_out, data_ready, primed, overrun
    );
endinterface

// File: rtl/filter_sequencer.sv
// Moving-average filter over 2^FilterDepthLog2 IMU samples, one shared adder walking X/Y/Z.
// Accept->data_ready is 8 cycles; ready only in IDLE, samples offered while busy are dropped and flag overrun.
module filter_sequencer #(
    parameter int FilterDepthLog2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    filter_sequencer_if.slave  bus
);
    localparam int N  = 1 << FilterDepthLog2;
    localparam int SW = 10 + FilterDepthLog2;
    localparam int AW = 12 + FilterDepthLog2;
    localparam int BW = FilterDepthLog2 + 2;
    localparam logic [FilterDepthLog2-1:0] PTR_ONE = 1;
    localparam logic [FilterDepthLog2:0]   CNT_ONE = 1;
    localparam logic [FilterDepthLog2:0]   CNT_N   = (FilterDepthLog2+1)'(N);

    typedef enum logic [1:0] {IDLE, READ, ACCUM, OUTPUT} state_t;

    state_t state, state_next;
    logic [1:0] axis;

    logic signed [9:0]    new_x, new_y, new_z;
    logic signed [9:0]    old_val;
    logic signed [9:0]    new_sel;
    logic signed [SW-1:0] sum_x, sum_y, sum_z;
    logic signed [SW-1:0] sum_sel, sum_upd;
    logic signed [AW-1:0] acc_wide;
    logic signed [SW-1:0] avg_x, avg_y, avg_z;

    logic [FilterDepthLog2-1:0] wr_ptr;
    logic [FilterDepthLog2:0]   count;
    logic [FilterDepthLog2:0]   count_next;
    logic                       count_full;

    logic signed [9:0] buffer [3*N];
    logic [BW-1:0]     buf_addr;

    logic signed [9:0] out_x, out_y, out_z;
    logic data_ready, primed, overrun;
    logic ready, accept, flush_now, drop;

    always_comb begin
        ready      = (state == IDLE);
        flush_now  = ready && bus.flush;
        accept     = ready && bus.sample_valid && !bus.flush;
        drop       = !ready && bus.sample_valid;
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = ACCUM;
            ACCUM:   state_next = (axis == 2'd2) ? OUTPUT : READ;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared datapath: axis index steers one adder across the three sums.
    always_comb begin
        new_sel = new_x;
        sum_sel = sum_x;
        case (axis)
            2'd1: begin
                new_sel = new_y;
                sum_sel = sum_y;
            end
            2'd2: begin
                new_sel = new_z;
                sum_sel = sum_z;
            end
            default: begin
                new_sel = new_x;
                sum_sel = sum_x;
            end
        endcase
        acc_wide = {{2{sum_sel[SW-1]}}, sum_sel}
                 + {{(AW-10){new_sel[9]}}, new_sel}
                 - {{(AW-10){old_val[9]}}, old_val};
        sum_upd    = acc_wide[SW-1:0];
        buf_addr   = {axis, wr_ptr};
        count_full = (count == CNT_N);
        count_next = count_full ? count : count + CNT_ONE;
        avg_x      = sum_x >>> FilterDepthLog2;
        avg_y      = sum_y >>> FilterDepthLog2;
        avg_z      = sum_z >>> FilterDepthLog2;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Sample history is deliberately never cleared; count masks stale words.
    always_ff @(posedge clk) begin
        if (state == ACCUM) buffer[buf_addr] <= new_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            axis       <= 2'd0;
            new_x      <= '0;
            new_y      <= '0;
            new_z      <= '0;
            old_val    <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            sum_z      <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_z      <= '0;
            data_ready <= 1'b0;
            primed     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (drop) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_now) begin
                        sum_x  <= '0;
                        sum_y  <= '0;
                        sum_z  <= '0;
                        wr_ptr <= '0;
                        count  <= '0;
                        primed <= 1'b0;
                    end else if (accept) begin
                        new_x <= bus.accel_x;
                        new_y <= bus.accel_y;
                        new_z <= bus.accel_z;
                        axis  <= 2'd0;
                    end
                end
                READ: begin
                    old_val <= count_full ? buffer[buf_addr] : '0;
                end
                ACCUM: begin
                    case (axis)
                        2'd0:    sum_x <= sum_upd;
                        2'd1:    sum_y <= sum_upd;
                        default: sum_z <= sum_upd;
                    endcase
                    axis <= axis + 2'd1;
                end
                OUTPUT: begin
                    out_x      <= avg_x[9:0];
                    out_y      <= avg_y[9:0];
                    out_z      <= avg_z[9:0];
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    count      <= count_next;
                    data_ready <= 1'b1;
                    if (count_next == CNT_N) primed <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = ready;
    assign bus.accel_x_out = out_x;
    assign bus.accel_y_out = out_y;
    assign bus.accel_z_out = out_z;
    assign bus.data_ready  = data_ready;
    assign bus.primed      = primed;
    assign bus.overrun     = overrun;
endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 Parameter: FilterDepthLog2, 8, log2 of window length N (N = 2^FilterDepthLog2, default 256 samples); legal range 1..10.
REQ-002 Clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 SampleValid  in  1  one-cycle pulse marking a new AccelX/Y/Z triple.
REQ-005 AccelX, AccelY, AccelZ  in  10 each  signed raw IMU axes, sampled when SampleValid=1 and Ready=1.
REQ-006 Flush  in  1  request to restart the window; honoured only while Ready=1.
REQ-007 Ready  out  1  high only in IDLE; a sample is accepted only when SampleValid=1 and Ready=1.
REQ-008 AccelXOut, AccelYOut, AccelZOut  out  10 each  signed windowed averages.
REQ-009 DataReady  out  1  one-cycle pulse when the outputs have updated.
REQ-010 Primed  out  1  high once N samples have been accepted since the last reset or flush.
REQ-011 Overrun  out  1  sticky flag set by a dropped sample.

Function
REQ-012 Single shared datapath: one sample buffer of 3*N 10-bit words, one adder/subtractor, and three running sums (SumX/Y/Z, signed, 10+FilterDepthLog2 bits), time-multiplexed across axes X, Y, Z in that order.
REQ-013 FSM states: IDLE, READ, ACCUM, OUTPUT; a 2-bit axis index selects X/Y/Z.
- IDLE -> READ (axis X) on accept.
- READ -> ACCUM.
- ACCUM -> READ (next axis), or -> OUTPUT after Z.
- OUTPUT -> IDLE.
REQ-014 Accept in cycle T: inputs are latched at the end of T; states occupy T+1..T+7; outputs update at the end of T+7; DataReady=1 and Ready=1 in T+8 only. The minimum accepted-sample spacing is 8 cycles.
REQ-015 READ: the buffer word at WrPtr for the current axis is fetched into OldVal; OldVal is forced to 0 while Count < N.
REQ-016 ACCUM: Sum <= Sum + New - OldVal, computed in 12+FilterDepthLog2 bits, then truncated to the sum width (the exact window sum always fits); New is written to the buffer at WrPtr for that axis.
REQ-017 OUTPUT: each AccelOut <= Sum >>> FilterDepthLog2 (arithmetic shift, rounds toward negative infinity).
- WrPtr increments, wrapping from N-1 to 0.
- Count increments, saturating at N.
REQ-018 Before priming, the output is the zero-padded average, i.e. the sum of accepted samples divided by N.
REQ-019 Primed <= 1 in the OUTPUT state in which Count reaches N; it stays high until reset or flush.
REQ-020 SampleValid=1 while Ready=0: the sample is dropped, Overrun <= 1, and the sequence in progress is unaffected.
REQ-021 Overrun is cleared only by Reset.
REQ-022 Flush=1 while Ready=1: SumX/Y/Z, WrPtr, Count and Primed clear; the outputs hold; no DataReady is generated.
REQ-023 Flush=1 and SampleValid=1 in the same IDLE cycle: Flush wins, the sample is discarded, and Overrun does not change.
REQ-024 Flush while Ready=0 is ignored.
REQ-025 Buffer contents are never cleared; stale data is masked by the rule in REQ-015.

Reset
REQ-026 Reset asserted in any cycle, including mid-sequence: at that edge the state goes to IDLE, with:
- SumX/Y/Z=0, WrPtr=0, Count=0;
- AccelXOut/Y/Z=0, DataReady=0, Primed=0, Overrun=0.
REQ-027 Ready=1 in the first cycle after Reset deasserts; a sequence interrupted by reset produces no DataReady.
REQ-028 Reset has priority over SampleValid and Flush.

Verification (bench uses FilterDepthLog2=2, N=4)
REQ-029 Reset, then accept X=100, Y=-8, Z=4 at T -> DataReady pulse in T+8 only; outputs 25, -2, 1; Primed=0.
REQ-030 Accept four samples X=-3 -> X out -3 and Primed=1 after the 4th; a 5th sample X=5 -> X out -1 (sum -4).
REQ-031 Accept at T, SampleValid again at T+3 -> second sample dropped; Overrun=1 and remains 1; outputs reflect the first sample only; one DataReady.
REQ-032 Accept at T, Reset at T+4 -> no DataReady; outputs 0; Ready=1 in T+5; next accepted X=8 -> X out 2.
REQ-033 Prime with four samples X=40, then Flush and SampleValid(X=40) together in IDLE -> no DataReady; Primed=0; Overrun=0; next X=40 -> X out 10.
REQ-034 Four samples of -512 on all axes -> outputs -512; then four samples of 511 -> outputs 511; no wrap-around at any step.
